// File: rtl/pe_group_seq.sv
// Tile sequencer for PE_Group: W/I/O read-address streams for a 1-D convolution, one tile at a time.
// Optional build macro PE_SEQ_PERF_EN adds stall_cycles/run_cycles performance counters.
module pe_group_seq #(
    parameter int unsigned W_Size     = 8,
    parameter int unsigned O_Size     = 8,
    parameter int unsigned W_TileSize = 8,
    parameter int unsigned O_TileSize = 4,
    parameter int unsigned AddrWidth  = 8
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AddrWidth-1:0] tile_idx,
    output logic                 W_AddrValid,
    input  logic                 W_AddrRdy,
    output logic [AddrWidth-1:0] W_Addr,
    output logic                 I_AddrValid,
    input  logic                 I_AddrRdy,
    output logic [AddrWidth-1:0] I_Addr,
    output logic                 O_AddrValid,
    input  logic                 O_AddrRdy,
    output logic [AddrWidth-1:0] O_Addr,
    input  logic                 Res_Fire
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          run_cycles
`endif
);
    localparam int unsigned NT = O_Size / O_TileSize;
    localparam int unsigned NK = W_Size / W_TileSize;
    localparam int unsigned LI = O_TileSize + W_TileSize - 1;
    localparam int unsigned CW = 16;

    localparam logic [CW-1:0]        WTotal   = CW'(W_Size);
    localparam logic [CW-1:0]        ITotal   = CW'(NK * LI);
    localparam logic [CW-1:0]        OTotal   = CW'(O_TileSize);
    localparam logic [AddrWidth-1:0] LastJ    = AddrWidth'(LI - 1);
    localparam logic [AddrWidth-1:0] LastTile = AddrWidth'(NT - 1);
    localparam logic [AddrWidth-1:0] OStep    = AddrWidth'(O_TileSize);
    localparam logic [AddrWidth-1:0] WStep    = AddrWidth'(W_TileSize);

    typedef enum logic [1:0] {StIdle, StLoad, StWait} stateT;

    stateT                state;
    logic [CW-1:0]        wCnt, iCnt, oCnt, resCnt;
    logic [AddrWidth-1:0] iJ, iKOff, tBase;

    logic                 wFire, iFire, oFire, resInc, loadDone, tileDrained;
    logic [CW-1:0]        wCntNext, iCntNext, oCntNext, resNext;
    logic [AddrWidth-1:0] iJNext, iKOffNext;

    always_comb begin
        wFire     = W_AddrValid && W_AddrRdy;
        iFire     = I_AddrValid && I_AddrRdy;
        oFire     = O_AddrValid && O_AddrRdy;
        wCntNext  = wCnt + CW'(wFire);
        iCntNext  = iCnt + CW'(iFire);
        oCntNext  = oCnt + CW'(oFire);
        iJNext    = iJ;
        iKOffNext = iKOff;
        if (iFire) begin
            if (iJ == LastJ) begin
                iJNext    = '0;
                iKOffNext = iKOff + WStep;
            end else begin
                iJNext = iJ + AddrWidth'(1);
            end
        end
        loadDone    = (wCntNext == WTotal) && (iCntNext == ITotal) && (oCntNext == OTotal);
        // Counter saturates at one tile's worth; surplus beats are dropped.
        resInc      = Res_Fire && (state != StIdle) && (resCnt != OTotal);
        resNext     = resCnt + CW'(resInc);
        tileDrained = (resNext == OTotal);
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state       <= StIdle;
            done        <= 1'b0;
            tile_idx    <= '0;
            tBase       <= '0;
            wCnt        <= '0;
            iCnt        <= '0;
            oCnt        <= '0;
            resCnt      <= '0;
            iJ          <= '0;
            iKOff       <= '0;
            W_AddrValid <= 1'b0;
            I_AddrValid <= 1'b0;
            O_AddrValid <= 1'b0;
            W_Addr      <= '0;
            I_Addr      <= '0;
            O_Addr      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StLoad;
                        tile_idx <= '0;
                        tBase    <= '0;
                        resCnt   <= '0;
                    end
                end
                StLoad: begin
                    resCnt      <= resNext;
                    W_AddrValid <= (wCntNext < WTotal);
                    I_AddrValid <= (iCntNext < ITotal);
                    O_AddrValid <= (oCntNext < OTotal);
                    W_Addr      <= AddrWidth'(wCntNext);
                    I_Addr      <= tBase + iKOffNext + iJNext;
                    O_Addr      <= tBase + AddrWidth'(oCntNext);
                    if (loadDone) begin
                        // Stream counters are idle in WAIT, so clear them here for the next tile.
                        state <= StWait;
                        wCnt  <= '0;
                        iCnt  <= '0;
                        oCnt  <= '0;
                        iJ    <= '0;
                        iKOff <= '0;
                    end else begin
                        wCnt  <= wCntNext;
                        iCnt  <= iCntNext;
                        oCnt  <= oCntNext;
                        iJ    <= iJNext;
                        iKOff <= iKOffNext;
                    end
                end
                StWait: begin
                    if (tileDrained) begin
                        resCnt <= '0;
                        if (tile_idx == LastTile) begin
                            state <= StIdle;
                            done  <= 1'b1;
                        end else begin
                            state    <= StLoad;
                            tile_idx <= tile_idx + AddrWidth'(1);
                            tBase    <= tBase + OStep;
                        end
                    end else begin
                        resCnt <= resNext;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic anyStall;

    assign anyStall = (state == StLoad) && ((W_AddrValid && !W_AddrRdy) ||
                                            (I_AddrValid && !I_AddrRdy) ||
                                            (O_AddrValid && !O_AddrRdy));

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            stall_cycles <= '0;
            run_cycles   <= '0;
        end else if (state == StIdle) begin
            if (start) begin
                stall_cycles <= '0;
                run_cycles   <= '0;
            end
        end else begin
            if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
            if (anyStall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_group_seq.sv
// Directed self-checking bench for pe_group_seq; a second instance runs with W_TileSize=4.
`timescale 1ns/1ps
module tb_pe_group_seq;
    localparam int AW     = 8;
    localparam int WSize  = 8;
    localparam int OTile  = 4;
    localparam int NT     = 2;
    localparam int Beats1 = 8 + 11 + 4;

    logic clk = 1'b0;
    logic aclr = 1'b0, start = 1'b0, resFire = 1'b0;
    logic wRdy = 1'b1, iRdy = 1'b1, oRdy = 1'b1;
    logic togI = 1'b0;

    logic          busy, dDone, wValid, iValid, oValid;
    logic [AW-1:0] tileIdx, wAddr, iAddr, oAddr;
    logic          busy2, dDone2, wValid2, iValid2, oValid2;
    logic [AW-1:0] tileIdx2, wAddr2, iAddr2, oAddr2;
`ifdef PE_SEQ_PERF_EN
    logic [31:0]   stallCycles, runCycles, stallCycles2, runCycles2;
`endif

    int nChecks = 0, nErrors = 0;
    int cyc = 0, startCyc = 0, doneCyc = 0, doneCnt = 0, done2Cnt = 0;
    logic [AW-1:0] wQ[$], iQ[$], oQ[$], w2Q[$], i2Q[$], o2Q[$];
    logic [AW-1:0] expW[$], expI[$], expO[$];
    logic          iHeld = 1'b0;
    logic [AW-1:0] iHeldAddr = '0;

    pe_group_seq dut (
        .clk(clk), .aclr(aclr), .start(start), .busy(busy), .done(dDone), .tile_idx(tileIdx),
        .W_AddrValid(wValid), .W_AddrRdy(wRdy), .W_Addr(wAddr),
        .I_AddrValid(iValid), .I_AddrRdy(iRdy), .I_Addr(iAddr),
        .O_AddrValid(oValid), .O_AddrRdy(oRdy), .O_Addr(oAddr),
        .Res_Fire(resFire)
`ifdef PE_SEQ_PERF_EN
        , .stall_cycles(stallCycles), .run_cycles(runCycles)
`endif
    );

    pe_group_seq #(.W_TileSize(4)) dut2 (
        .clk(clk), .aclr(aclr), .start(start), .busy(busy2), .done(dDone2), .tile_idx(tileIdx2),
        .W_AddrValid(wValid2), .W_AddrRdy(wRdy), .W_Addr(wAddr2),
        .I_AddrValid(iValid2), .I_AddrRdy(iRdy), .I_Addr(iAddr2),
        .O_AddrValid(oValid2), .O_AddrRdy(oRdy), .O_Addr(oAddr2),
        .Res_Fire(resFire)
`ifdef PE_SEQ_PERF_EN
        , .stall_cycles(stallCycles2), .run_cycles(runCycles2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Beats are logged on the falling edge, before the rising edge that transfers them.
    always @(negedge clk) begin
        if (wValid && wRdy) wQ.push_back(wAddr);
        if (iValid && iRdy) iQ.push_back(iAddr);
        if (oValid && oRdy) oQ.push_back(oAddr);
        if (wValid2 && wRdy) w2Q.push_back(wAddr2);
        if (iValid2 && iRdy) i2Q.push_back(iAddr2);
        if (oValid2 && oRdy) o2Q.push_back(oAddr2);
        if (dDone) begin doneCnt++; doneCyc = cyc; end
        if (dDone2) done2Cnt++;
        if (iHeld && aclr) begin
            check("i_hold_valid", 32'(iValid), 1);
            check("i_hold_addr", 32'(iAddr), 32'(iHeldAddr));
        end
        iHeld     = iValid && !iRdy && aclr;
        iHeldAddr = iAddr;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (togI) iRdy = ~iRdy;
    endtask

    task automatic buildExp(input int wt);
        int nk, li;
        nk = WSize / wt;
        li = OTile + wt - 1;
        expW.delete(); expI.delete(); expO.delete();
        for (int t = 0; t < NT; t++) begin
            for (int k = 0; k < nk; k++)
                for (int j = 0; j < wt; j++) expW.push_back(AW'(k * wt + j));
            for (int k = 0; k < nk; k++)
                for (int j = 0; j < li; j++) expI.push_back(AW'(t * OTile + k * wt + j));
            for (int j = 0; j < OTile; j++) expO.push_back(AW'(t * OTile + j));
        end
    endtask

    task automatic cmpQ(input string tag, input logic [AW-1:0] got[$], input logic [AW-1:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic startJob();
        aclr = 1'b0;
        step();
        aclr = 1'b1;
        step();
        wQ.delete(); iQ.delete(); oQ.delete(); w2Q.delete(); i2Q.delete(); o2Q.delete();
        doneCnt  = 0;
        done2Cnt = 0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        startCyc = cyc;
        check("load_busy", 32'(busy), 1);
        check("load_entry_valids", 32'({wValid, iValid, oValid}), 0);
    endtask

    // mode 0: results after LOAD; 1: early results; 2: early + surplus in WAIT; 3: start held
    task automatic runJob(input int mode, input int expLat);
        int n;
        bit early;
        early = (mode == 1) || (mode == 2);
        for (int t = 0; t < NT; t++) begin
            if (early) begin
                resFire = 1'b1;
                repeat (4) step();
                resFire = 1'b0;
            end else if (mode == 0 && t == 0) begin
                step();
                check("first_valids", 32'({wValid, iValid, oValid}), 32'b111);
                check("first_addrs", 32'({wAddr, iAddr, oAddr}), 0);
            end
            start = (mode == 3);
            n = 0;
            while (wQ.size() + iQ.size() + oQ.size() < (t + 1) * Beats1 && n < 200) begin
                step();
                n++;
            end
            check("tile_beats", 32'(wQ.size() + iQ.size() + oQ.size()), 32'((t + 1) * Beats1));
`ifdef PE_SEQ_PERF_EN
            if (t == 0 && togI) check("stall_tile0", stallCycles, 11);
`endif
            if (early) begin
                if (t == 0) begin
                    check("wait_tile_idx", 32'(tileIdx), 0);
                    check("wait_valids", 32'({wValid, iValid, oValid}), 0);
                end
                resFire = (mode == 2);
                step();
                resFire = 1'b0;
                if (t == 0) begin
                    check("next_tile_idx", 32'(tileIdx), 1);
                    check("next_tile_busy", 32'(busy), 1);
                end
            end else begin
                resFire = 1'b1;
                repeat (4) step();
                resFire = 1'b0;
            end
            start = 1'b0;
        end
        n = 0;
        while (doneCnt == 0 && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        check("done_count", 32'(doneCnt), 1);
        check("done_latency", 32'(doneCyc - startCyc), 32'(expLat));
        check("idle_busy", 32'(busy), 0);
        check("idle_tile_idx", 32'(tileIdx), 1);
        buildExp(8);
        cmpQ("w", wQ, expW);
        cmpQ("i", iQ, expI);
        cmpQ("o", oQ, expO);
    endtask

    initial begin
        int n;
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(dDone), 0);
        check("rst_tile_idx", 32'(tileIdx), 0);
        check("rst_valids", 32'({wValid, iValid, oValid}), 0);
        check("rst_addrs", 32'({wAddr, iAddr, oAddr}), 0);

        // Defaults, all ready, with a W_TileSize=4 instance alongside.
        startJob();
        runJob(0, 32);
`ifdef PE_SEQ_PERF_EN
        check("run_cycles", runCycles, 32);
        check("stall_none", stallCycles, 0);
`endif
        n = 0;
        while (done2Cnt == 0 && n < 100) begin step(); n++; end
        check("dut2_done", 32'(done2Cnt), 1);
        buildExp(4);
        cmpQ("w2", w2Q, expW);
        cmpQ("i2", i2Q, expI);
        cmpQ("o2", o2Q, expO);

        // I-stream backpressure, ready toggling each cycle; first valid cycle sees ready low.
        iRdy = 1'b0;
        togI = 1'b1;
        startJob();
        runJob(0, 53);
        togI = 1'b0;
        iRdy = 1'b1;

        startJob();
        runJob(1, 26);
        startJob();
        runJob(2, 26);
        startJob();
        runJob(3, 32);

        // Reset in the middle of LOAD, then a clean restart.
        startJob();
        n = 0;
        while (wQ.size() < 3 && n < 20) begin step(); n++; end
        check("pre_rst_wbeats", 32'(wQ.size()), 3);
        aclr = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valids", 32'({wValid, iValid, oValid}), 0);
        check("mid_rst_tile_idx", 32'(tileIdx), 0);
        step();
        aclr = 1'b1;
        startJob();
        runJob(0, 32);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_group_seq.md
Name: pe_group_seq

Overview:
Tile sequencer for PE_Group. It generates the off-chip read-address streams for the weight (W), input (I) and partial-output (O) operands of a 1-D convolution, out[o] += sum_k w[k]*in[o+k], one output tile at a time. Each stream uses a valid/rdy handshake. The sequencer also counts result handshakes on PE_Group's O_DataOut port, and only advances to the next tile once the current tile has fully drained.

Parameters:
W_Size, 8, total weight taps
O_Size, 8, total outputs; input length is O_Size+W_Size-1
W_TileSize, 8, weight taps per weight block; must divide W_Size
O_TileSize, 4, outputs per tile; equals PE_Group O_PEGroupSize and must divide O_Size
AddrWidth, 8, address width; must hold O_Size+W_Size-2

Ports:
clk  in  1  clock; all state changes on the rising edge
aclr  in  1  asynchronous reset, active-low (aclr=0 resets)
start  in  1  one-cycle pulse; sampled only in IDLE
busy  out  1  high in LOAD or WAIT
done  out  1  one-cycle pulse when the last tile completes
tile_idx  out  AddrWidth  current output tile index t
W_AddrValid  out  1  W address valid
W_AddrRdy  in  1  W consumer ready
W_Addr  out  AddrWidth  weight address
I_AddrValid  out  1  I address valid
I_AddrRdy  in  1  I consumer ready
I_Addr  out  AddrWidth  input address
O_AddrValid  out  1  O address valid
O_AddrRdy  in  1  O consumer ready
O_Addr  out  AddrWidth  partial-output address
Res_Fire  in  1  PE_Group O_DataOutValid && O_DataOutRdy

Behaviour:
- Reset (aclr=0, asynchronous): state=IDLE; all counters=0; busy, done and all *_AddrValid=0; all addresses=0; tile_idx=0.
- NT = O_Size/O_TileSize tiles. NK = W_Size/W_TileSize weight blocks. LI = O_TileSize+W_TileSize-1.
- IDLE: start=1 moves to LOAD with t=0 and all stream counters cleared. start is ignored in every other state.
- LOAD: the three streams run independently and concurrently. Each stream:
  - Valid is registered, and is high while that stream has addresses left for the tile.
  - A beat transfers on Valid&&Rdy; the address advances in the following cycle.
  - Address and Valid hold while Rdy=0.
  - A stream holds no bubbles between beats.
- W stream: for k=0..NK-1, j=0..W_TileSize-1: address k*W_TileSize+j. Count per tile: W_Size.
- I stream: for k=0..NK-1, j=0..LI-1: address t*O_TileSize+k*W_TileSize+j. Count per tile: NK*LI.
- O stream: j=0..O_TileSize-1: address t*O_TileSize+j, issued once per tile. Count per tile: O_TileSize.
- The first valid beat of each stream appears in the cycle after LOAD is entered.
- LOAD to WAIT: when all three streams have transferred their final beat; the cycle of the last transfer counts. All Valids are 0 in WAIT.
- Result counting: a result counter increments on every Res_Fire in LOAD or WAIT. Res_Fire in IDLE is ignored.
- WAIT: when the result count reaches O_TileSize (including a Res_Fire in the current cycle), the result count clears.
  - If t<NT-1: t increments and the next state is LOAD.
  - Otherwise: the next state is IDLE and done pulses for one cycle.
- Results arriving early (during LOAD) are counted. If O_TileSize results arrive before LOAD ends, WAIT lasts exactly 1 cycle.
- Result overflow: a Res_Fire once the count already equals O_TileSize saturates the counter, and the extra beat is dropped.
- tile_idx = t, valid while busy; it holds its last value in IDLE.
- Reset mid-operation: all streams are abandoned immediately, with no partial beats retained.

Optional Feature:
PE_SEQ_PERF_EN
- Defined: adds outputs stall_cycles[31:0] and run_cycles[31:0].
  - run_cycles counts cycles with busy=1.
  - stall_cycles counts cycles in LOAD where any Valid=1 with its Rdy=0.
  - Both clear on start, hold in IDLE, saturate at all-ones, and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Defaults, all Rdy=1, Res_Fire pulsed 4x after each LOAD:
  - Tile0: W 0..7, I 0..10, O 0..3. Tile1: W 0..7, I 4..14, O 4..7.
  - done pulses once; totals are 16 W, 22 I, 8 O beats.
- Backpressure: I_AddrRdy toggles 1/0 every cycle -> I_Addr holds during Rdy=0, no address is skipped or duplicated, and W/O streams complete unaffected. Under PE_SEQ_PERF_EN, stall_cycles=11 for tile0.
- Early results: 4 Res_Fire during LOAD of tile0 -> WAIT lasts 1 cycle, then tile_idx=1.
- Parameters W_TileSize=4 (NK=2): tile0 W 0..7, I 0..6 then 4..10, O 0..3.
- Reset mid-LOAD (aclr=0 after 3 W beats): all Valid=0 and busy=0 asynchronously. A new start restarts at W 0, I 0, O 0.
- start asserted while busy -> ignored; the sequence is identical to a single-start run. 5th Res_Fire in WAIT -> count saturates and done timing is unchanged.
